// File: rtl/sar_search4.sv
// Successive-approximation search controller: finds a target, MSB first, using an external comparator.
// Latency: done pulses WIDTH+1 cycles after the accepted start edge (sooner on error or early exit).
// No backpressure: start is taken only in IDLE and ignored while a search is running.
// Optional feature macro: SAR_SEARCH_EARLY_EXIT_EN (finish as soon as the comparator reports equality).
module sar_search4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] probe,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       steps
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    bit_idx;
    logic [IW-1:0]    bit_nxt;
    logic [WIDTH-1:0] probe_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic [WIDTH-1:0] res_upd;
    logic             err_nxt;
    logic [2:0]       steps_nxt;
    logic             flags_ok;
    logic             keep_bit;

    assign flags_ok = $onehot({cmp_gt, cmp_lt, cmp_eq});
    assign keep_bit = cmp_gt | cmp_eq;

    // Status outputs are pure decodes of the state register.
    assign busy = (state == TRY);
    assign done = (state == DONE);

    // Next-state and datapath: everything holds unless a state explicitly updates it.
    always_comb begin
        state_nxt  = state;
        bit_nxt    = bit_idx;
        probe_nxt  = probe;
        result_nxt = result;
        err_nxt    = err;
        steps_nxt  = steps;
        res_upd    = result;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = TRY;
                    probe_nxt  = ONE << (WIDTH - 1);
                    result_nxt = '0;
                    err_nxt    = 1'b0;
                    steps_nxt  = 3'd0;
                    bit_nxt    = IW'(WIDTH - 1);
                end
            end
            TRY: begin
                steps_nxt = steps + 3'd1;
                if (!flags_ok) begin
                    // Broken comparator: freeze the partial result and report.
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
                else if (cmp_eq) begin
                    result_nxt = probe;
                    state_nxt  = DONE;
                end
`endif
                else begin
                    // probe is result with the trial bit set, so keeping the bit means taking probe.
                    res_upd    = keep_bit ? probe : result;
                    result_nxt = res_upd;
                    if (bit_idx == '0) begin
                        state_nxt = DONE;
                    end else begin
                        probe_nxt = res_upd | (ONE << (bit_idx - 1'b1));
                        bit_nxt   = bit_idx - 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that aborts any search.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_idx <= '0;
            probe   <= '0;
            result  <= '0;
            err     <= 1'b0;
            steps   <= 3'd0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_nxt;
            probe   <= probe_nxt;
            result  <= result_nxt;
            err     <= err_nxt;
            steps   <= steps_nxt;
        end
    end

endmodule

// File: tb/tb_sar_search4.sv
// Self-checking bench for sar_search4 with an ideal comparator and fault injection.
// Latency: checks every cycle of each search against a bit-arithmetic reference.
// Backpressure: exercises start held high across back-to-back searches.
module tb_sar_search4;

    localparam int W = 4;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cmp_gt;
    logic         cmp_lt;
    logic         cmp_eq;
    logic [W-1:0] probe;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
    logic         err;
    logic [2:0]   steps;

    logic [W-1:0] target = '0;
    logic         bad = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Ideal combinational comparator; bad forces an illegal two-hot pattern.
    assign cmp_gt = bad | (target > probe);
    assign cmp_lt = bad | (target < probe);
    assign cmp_eq = ~bad & (target == probe);

    sar_search4 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .probe  (probe),
        .result (result),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .steps  (steps)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Target value with only its top k bits retained.
    function automatic int top_bits(input int t, input int k);
        return t & ~((1 << (W - k)) - 1) & ((1 << W) - 1);
    endfunction

    // One search: bad_at injects a two-hot flag in that TRY cycle, rst_at asserts reset in it.
    task automatic run_search(input int t, input bit hold, input int bad_at_i, input int rst_at_i);
        int pq[$];
        int n;
        int last;
        int bad_at;
        int rst_at;
        int res_exp;
        bad_at = bad_at_i;
        rst_at = rst_at_i;
        // Reference: probe i is the target's higher bits plus trial bit i.
        for (int i = W - 1; i >= 0; i--) begin
            int p;
            p = top_bits(t, W - 1 - i) | (1 << i);
            pq.push_back(p);
            if (EARLY && p == t) break;
        end
        n = pq.size();
        if (bad_at >= n) bad_at = -1;
        if (rst_at >= n) rst_at = -1;
        last = (bad_at >= 0) ? bad_at : n - 1;
        res_exp = (bad_at >= 0) ? top_bits(t, bad_at) : t;

        target = t[W-1:0];
        start  = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int k = 0; k <= last; k++) begin
            chk("try_probe", probe, pq[k]);
            chk("try_busy", busy, 1);
            chk("try_done", done, 0);
            chk("try_steps", steps, k);
            chk("try_err", err, 0);
            if (k == 0) chk("try_result0", result, 0);
            if (k == bad_at) bad = 1'b1;
            if (k == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            bad = 1'b0;
            if (k == rst_at) begin
                chk("rst_probe", probe, 0);
                chk("rst_result", result, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                chk("rst_steps", steps, 0);
                rst   = 1'b0;
                start = 1'b0;
                @(posedge clk); #1;
                chk("rst_no_done", done, 0);
                return;
            end
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_result", result, res_exp);
        chk("done_steps", steps, last + 1);
        chk("done_err", err, (bad_at >= 0) ? 1 : 0);
        chk("done_probe", probe, pq[last]);
        @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_result", result, res_exp);
        chk("idle_steps", steps, last + 1);
        chk("idle_err", err, (bad_at >= 0) ? 1 : 0);
        chk("idle_probe", probe, pq[last]);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_probe", probe, 0);
        chk("reset_result", result, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_steps", steps, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed targets, including both range ends and the early-exit case.
        run_search(11, 1'b0, -1, -1);
        run_search(0, 1'b0, -1, -1);
        run_search(15, 1'b0, -1, -1);
        run_search(8, 1'b0, -1, -1);

        // Illegal flags in the second TRY cycle.
        run_search(5, 1'b0, 1, -1);
        run_search(13, 1'b0, 1, -1);

        // Reset in the third TRY cycle, then a full search.
        run_search(3, 1'b0, -1, 2);
        run_search(6, 1'b0, -1, -1);

        // Random targets.
        for (int i = 0; i < 24; i++) begin
            run_search($urandom_range(0, (1 << W) - 1), 1'b0, -1, -1);
        end

        // Random fault injection and reset aborts.
        for (int i = 0; i < 6; i++) begin
            run_search($urandom_range(0, (1 << W) - 1), 1'b0, $urandom_range(0, W - 1), -1);
            run_search($urandom_range(0, (1 << W) - 1), 1'b0, -1, $urandom_range(0, W - 1));
        end

        // start held high: back-to-back searches, one done pulse each.
        for (int i = 0; i < 5; i++) begin
            run_search($urandom_range(0, (1 << W) - 1), 1'b1, -1, -1);
        end
        start = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sar_search4.md
SAR_SEARCH4 -- requirements
Module: sar_search4

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, bit width of the probe and result.
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  search request, sampled in IDLE only.
REQ-005 SHALL have port: cmp_gt  input  1  external comparator flag, target > probe.
REQ-006 SHALL have port: cmp_lt  input  1  external comparator flag, target < probe.
REQ-007 SHALL have port: cmp_eq  input  1  external comparator flag, target == probe.
REQ-008 SHALL have port: probe  output  WIDTH  registered trial value driven to the comparator.
REQ-009 SHALL have port: result  output  WIDTH  converged target value, held until the next start.
REQ-010 SHALL have port: busy  output  1  high while the search is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse at search completion.
REQ-012 SHALL have port: err  output  1  comparator flags were not one-hot; held until the next start.
REQ-013 SHALL have port: steps  output  3  number of TRY cycles consumed by the last search.

Function
REQ-014 SHALL implement the FSM states IDLE, TRY and DONE.
REQ-015 SHALL, in IDLE with start=1 at edge t, enter TRY at t+1 with probe=1 followed by WIDTH-1 zeros, result=0, busy=1, err=0 and steps=0.
REQ-016 SHALL, in each TRY cycle, sample the flags at the edge for the probe currently driven; the comparator is combinational, and the flags must be valid within that cycle.
REQ-017 SHALL, at TRY bit i, keep bit i of result when cmp_gt or cmp_eq is set and clear it when cmp_lt is set.
REQ-018 SHALL drive the next probe as the updated result OR'd with bit i-1, and increment steps each TRY cycle.
REQ-019 SHALL, after bit 0 is processed, enter DONE; without early exit, done is asserted exactly WIDTH+1 cycles after the start edge.
REQ-020 SHALL, in DONE, assert done=1 and busy=0 for one cycle, then return to IDLE.
REQ-021 SHALL keep probe, result, steps and err stable from DONE until the next accepted start.
REQ-022 SHALL, in TRY, treat flags that are not exactly one-hot (none set, or more than one set) as an error: set err=1, leave result unchanged and go to DONE.
REQ-023 SHALL ignore start while in TRY or DONE, with no restart and no effect on the search.
REQ-024 SHALL accept start in the cycle immediately after DONE, giving back-to-back searches.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set state=IDLE, probe=0, result=0, busy=0, done=0, err=0 and steps=0.
REQ-026 SHALL give rst priority over start and abort any search in progress without asserting done.

Configuration
REQ-027 SHALL support the macro SAR_SEARCH_EARLY_EXIT_EN.
REQ-028 SHALL, when SAR_SEARCH_EARLY_EXIT_EN is defined, on cmp_eq=1 in TRY set result=probe and go to DONE immediately, with steps equal to the TRY cycles used.
REQ-029 SHALL, when SAR_SEARCH_EARLY_EXIT_EN is undefined, always run exactly WIDTH TRY cycles and treat cmp_eq as "keep bit".

Verification
REQ-030 SHALL verify, with an ideal comparator model, target=11 and macro off: probes 8,12,10,11; result=11; steps=4; done at start+5.
REQ-031 SHALL verify target=0: probes 8,4,2,1; result=0; err=0; and target=15: probes 8,12,14,15; result=15.
REQ-032 SHALL verify, with the macro on, target=8: probe 8 gives eq; done at start+2; result=8; steps=1.
REQ-033 SHALL verify that forcing cmp_gt=cmp_lt=1 in the second TRY cycle gives err=1, done pulse, result unchanged and steps=2.
REQ-034 SHALL verify that rst asserted in the third TRY cycle leaves all outputs 0 next cycle with no done pulse, and that a new start then runs a full search.
REQ-035 SHALL verify that start held high throughout gives back-to-back searches with the ignored-while-busy rule respected and one done pulse per search.
